// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared types, legal parameter ranges and the operation
// function for logic_op_unit.
package logic_op_pkg;

    // Operation codes; all eight values are defined.
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;
    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 8;

    // Combine the first num_in operands (each WIDTH_MAX wide, zero-padded)
    // under op. The inverted ops complement the full NUM_IN-wide reduction,
    // so XNOR is per-bit even parity rather than a pairwise chain.
    function automatic logic [WIDTH_MAX-1:0] op_compute(
        input op_e                              op,
        input logic [NUM_IN_MAX*WIDTH_MAX-1:0]  ops,
        input int                               num_in
    );
        logic [WIDTH_MAX-1:0] r_and;
        logic [WIDTH_MAX-1:0] r_or;
        logic [WIDTH_MAX-1:0] r_xor;
        logic [WIDTH_MAX-1:0] r;
        r_and = ops[0 +: WIDTH_MAX];
        r_or  = ops[0 +: WIDTH_MAX];
        r_xor = ops[0 +: WIDTH_MAX];
        for (int k = 1; k < NUM_IN_MAX; k++) begin
            if (k < num_in) begin
                r_and = r_and & ops[k*WIDTH_MAX +: WIDTH_MAX];
                r_or  = r_or  | ops[k*WIDTH_MAX +: WIDTH_MAX];
                r_xor = r_xor ^ ops[k*WIDTH_MAX +: WIDTH_MAX];
            end
        end
        case (op)
            OP_AND:  r = r_and;
            OP_OR:   r = r_or;
            OP_XOR:  r = r_xor;
            OP_NAND: r = ~r_and;
            OP_NOR:  r = ~r_or;
            OP_XNOR: r = ~r_xor;
            OP_PASS: r = ops[0 +: WIDTH_MAX];
            default: r = ~ops[0 +: WIDTH_MAX];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_unit_if.sv
// logic_op_unit_if: operand/result stream bundle for logic_op_unit.
// Optional reduction outputs exist only with LOGIC_OP_UNIT_REDUCE_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid/payload until accepted; ready never
// depends combinationally on valid, and the unit's ready/valid come from
// registered FIFO occupancy only.
interface logic_op_unit_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CNT_W-1:0]        res_count;
`ifdef LOGIC_OP_UNIT_REDUCE_EN
    logic                    out_red_and;
    logic                    out_red_or;
    logic                    out_red_xor;
`endif

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, res_count
`ifdef LOGIC_OP_UNIT_REDUCE_EN
        , input out_red_and, out_red_or, out_red_xor
`endif
    );

    // The logic unit itself
    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, res_count
`ifdef LOGIC_OP_UNIT_REDUCE_EN
        , output out_red_and, out_red_or, out_red_xor
`endif
    );

endinterface

// File: rtl/logic_op_fifo2.sv
// logic_op_fifo2: 2-entry in-order buffer. Entry e0 is always the head, so
// the read data comes straight from a register. Ready/valid are decoded
// from the registered occupancy count only.
module logic_op_fifo2 #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [PW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [PW-1:0] rd_data
);
    logic [1:0]    count;
    logic [PW-1:0] e0;
    logic [PW-1:0] e1;
    logic          push;
    logic          pop;

    assign wr_ready = (count != 2'd2);
    assign rd_valid = (count != 2'd0);
    assign rd_data  = e0;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    // Occupancy and storage update; push+pop at count 1 replaces the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        e0    <= wr_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0 <= wr_data;
                    end else if (push) begin
                        e1    <= wr_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push is possible, a pop promotes e1.
                    if (pop) begin
                        e0    <= e1;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/logic_op_unit.sv
// logic_op_unit: registered NUM_IN-operand bitwise logic unit with a
// 2-entry output buffer and a saturating delivered-result counter.
// Optional feature macro: LOGIC_OP_UNIT_REDUCE_EN (per-entry AND/OR/XOR
// reductions of the result word).
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    logic_op_unit_if.slave  bus
);
`ifdef LOGIC_OP_UNIT_REDUCE_EN
    localparam int PW = WIDTH + 3;
`else
    localparam int PW = WIDTH;
`endif

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("logic_op_unit: WIDTH out of range");
    end
    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
        $error("logic_op_unit: NUM_IN out of range");
    end

    logic [NUM_IN_MAX*WIDTH_MAX-1:0] ops_pad;
    logic [WIDTH-1:0]                result;
    logic [PW-1:0]                   wr_payload;
    logic [PW-1:0]                   rd_payload;
    logic                            out_valid_i;

    // Spread the packed operands into the function's fixed-size slots.
    always_comb begin
        ops_pad = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            ops_pad[k*WIDTH_MAX +: WIDTH] = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign result = WIDTH'(op_compute(op_e'(bus.in_op), ops_pad, NUM_IN));

`ifdef LOGIC_OP_UNIT_REDUCE_EN
    assign wr_payload      = {^result, |result, &result, result};
    assign bus.out_red_and = rd_payload[WIDTH];
    assign bus.out_red_or  = rd_payload[WIDTH+1];
    assign bus.out_red_xor = rd_payload[WIDTH+2];
`else
    assign wr_payload = result;
`endif

    logic_op_fifo2 #(.PW(PW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (bus.in_valid),
        .wr_ready (bus.in_ready),
        .wr_data  (wr_payload),
        .rd_valid (out_valid_i),
        .rd_ready (bus.out_ready),
        .rd_data  (rd_payload)
    );

    assign bus.out_valid = out_valid_i;
    assign bus.out_data  = rd_payload[WIDTH-1:0];

    // Count delivered results, holding at the all-ones maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.res_count <= '0;
        end else if (out_valid_i && bus.out_ready && (bus.res_count != {CNT_W{1'b1}})) begin
            bus.res_count <= bus.res_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_op_unit.sv
// tb_logic_op_unit: directed bench for logic_op_unit (WIDTH=8, NUM_IN=3,
// CNT_W=4) with a per-bit counting model and a queue scoreboard.
module tb_logic_op_unit;
    localparam int W  = 8;
    localparam int NI = 3;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_op_unit_if #(.WIDTH(W), .NUM_IN(NI), .CNT_W(CW)) bus ();

    logic_op_unit #(.WIDTH(W), .NUM_IN(NI), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: per bit, count how many operands are 1 and apply the op rule.
    function automatic logic [W-1:0] model_op(input int op, input logic [NI*W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < NI; k++) ones += int'(d[k*W + b]);
            case (op)
                0: r[b] = (ones == NI);
                1: r[b] = (ones > 0);
                2: r[b] = (ones % 2 == 1);
                3: r[b] = (ones != NI);
                4: r[b] = (ones == 0);
                5: r[b] = (ones % 2 == 0);
                6: r[b] = d[b];
                default: r[b] = !d[b];
            endcase
        end
        return r;
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            int pre;
            pre = exp_q.size();
            check("out_valid", 64'(bus.out_valid), 64'(pre != 0));
            check("in_ready", 64'(bus.in_ready), 64'(pre != 2));
            check("res_count", 64'(bus.res_count), 64'(m_cnt));
            if (pre != 0) begin
                check("out_data", 64'(bus.out_data), 64'(exp_q[0]));
`ifdef LOGIC_OP_UNIT_REDUCE_EN
                check("red_and", 64'(bus.out_red_and), 64'(&exp_q[0]));
                check("red_or", 64'(bus.out_red_or), 64'(|exp_q[0]));
                check("red_xor", 64'(bus.out_red_xor), 64'(^exp_q[0]));
`endif
                if (bus.out_ready) begin
                    obs_q.push_back(bus.out_data);
                    void'(exp_q.pop_front());
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (bus.in_valid && pre != 2)
                exp_q.push_back(model_op(int'(bus.in_op), bus.in_data));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [NI*W-1:0] d);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) check("send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.out_valid && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) check("drain_timeout", 64'(0), 64'(1));
    endtask

    // ---------------- directed tests ----------------
    logic [NI*W-1:0] d3;
    logic [W-1:0] lit_ops[8];
    logic [W-1:0] lit_and[4];
    logic [W-1:0] lit_bp[3];

    initial begin
        d3 = {8'hF0, 8'h0F, 8'hA5};
        lit_ops = '{8'h00, 8'hFF, 8'h5A, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'h5A};
        lit_and = '{8'h00, 8'h00, 8'h00, 8'hFF};
        lit_bp  = '{8'h5A, 8'hA5, 8'hFF};
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'(1));
        check("idle_out_valid", 64'(bus.out_valid), 64'(0));
        check("idle_out_data", 64'(bus.out_data), 64'(0));
        check("idle_res_count", 64'(bus.res_count), 64'(0));
        @(posedge clk);
        #1;

        // AND over pairs; third operand FF so the 3-input AND equals the pair AND
        bus.out_ready = 1'b1;
        obs_q.delete();
        send(3'd0, {8'hFF, 8'h00, 8'h00});
        check("latency_valid", 64'(bus.out_valid), 64'(1));
        check("latency_data", 64'(bus.out_data), 64'(8'h00));
        send(3'd0, {8'hFF, 8'hFF, 8'h00});
        send(3'd0, {8'hFF, 8'h00, 8'hFF});
        send(3'd0, {8'hFF, 8'hFF, 8'hFF});
        drain();
        check("and_count", 64'(obs_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check("and_result", 64'(obs_q[i]), 64'(lit_and[i]));
        check("and_res_count", 64'(bus.res_count), 64'(4));

        // All eight ops over A5,0F,F0; pin the model against hand values first
        for (int op = 0; op < 8; op++)
            check("model_pin", 64'(model_op(op, d3)), 64'(lit_ops[op]));
        @(posedge clk);
        #1;
        obs_q.delete();
        for (int op = 0; op < 8; op++) send(3'(op), d3);
        drain();
        check("ops_count", 64'(obs_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < obs_q.size(); i++)
            check("ops_result", 64'(obs_q[i]), 64'(lit_ops[i]));
        check("ops_res_count", 64'(bus.res_count), 64'(12));

        // Backpressure: two accepted, the third held until out_ready rises
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        obs_q.delete();
        send(3'd2, d3);
        send(3'd6, d3);
        check("bp_full_ready", 64'(bus.in_ready), 64'(0));
        fork
            send(3'd1, d3);
            begin
                repeat (3) @(negedge clk);
                check("bp_held_ready", 64'(bus.in_ready), 64'(0));
                check("bp_head", 64'(bus.out_data), 64'(8'h5A));
`ifdef LOGIC_OP_UNIT_REDUCE_EN
                check("bp_red_and", 64'(bus.out_red_and), 64'(0));
                check("bp_red_or", 64'(bus.out_red_or), 64'(1));
                check("bp_red_xor", 64'(bus.out_red_xor), 64'(0));
`endif
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(obs_q.size()), 64'(3));
        for (int i = 0; i < 3 && i < obs_q.size(); i++)
            check("bp_order", 64'(obs_q[i]), 64'(lit_bp[i]));
        check("bp_res_count", 64'(bus.res_count), 64'(15));

        // Simultaneous push/pop at count 1 for 10 cycles
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        obs_q.delete();
        send(3'd0, {8'd0, 8'd0, 8'd0});
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            send(3'(k % 8), {8'(k), 8'(k * 17), 8'(k * 3)});
            check("pp_valid", 64'(bus.out_valid), 64'(1));
            check("pp_ready", 64'(bus.in_ready), 64'(1));
        end
        drain();
        check("pp_count", 64'(obs_q.size()), 64'(11));
        for (int k = 1; k <= 10 && k < obs_q.size(); k++)
            check("pp_order", 64'(obs_q[k]), 64'(model_op(k % 8, {8'(k), 8'(k * 17), 8'(k * 3)})));
        check("sat_res_count", 64'(bus.res_count), 64'(15));

        // Asynchronous reset with two entries held
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(3'd2, d3);
        send(3'd1, d3);
        check("pre_rst_ready", 64'(bus.in_ready), 64'(0));
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_in_ready", 64'(bus.in_ready), 64'(1));
        check("arst_out_data", 64'(bus.out_data), 64'(0));
        check("arst_res_count", 64'(bus.res_count), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        send(3'd7, d3);
        check("post_rst_valid", 64'(bus.out_valid), 64'(1));
        check("post_rst_data", 64'(bus.out_data), 64'(8'h5A));
        drain();
        check("post_rst_res_count", 64'(bus.res_count), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/logic_op_unit.md
# logic_op_unit

Parametrised, registered bitwise logic unit: the next generation of the team's two-input `and_gate`. It combines NUM_IN operands of WIDTH bits under a runtime-selected operation (AND/OR/XOR/NAND/NOR/XNOR/PASS/NOT) and delivers results through a valid/ready stream with a 2-entry output buffer. It sits between any operand producer and consumer in the datapath and keeps a saturating count of delivered results.

## Interface
- WIDTH, 8, operand and result width in bits (1..64)
- NUM_IN, 2, operand count (2..8)
- CNT_W, 16, width of the result counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  unit can accept an operand set
- in_op  in  3  operation code, sampled with in_data
- in_data  in  NUM_IN*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result word
- res_count  out  CNT_W  results delivered since reset, saturating

## Operation
- Ops: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR (all across all NUM_IN operands), 6 PASS (operand 0), 7 NOT (~operand 0).
- NAND/NOR/XNOR are the bitwise complement of the NUM_IN-wide AND/OR/XOR. XNOR is therefore even-parity per bit, not a pairwise chain.
- Accept occurs when in_valid && in_ready. The result is computed combinationally from in_op/in_data and written into the buffer on that edge.
- Output buffer: 2-entry FIFO with count 0..2.
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - out_data is the head entry.
- Push and pop in the same cycle leave count unchanged and preserve order.
- Pop occurs when out_valid && out_ready. On each pop, res_count increments and holds at 2^CNT_W-1.
- out_data and the op are stable while out_valid && !out_ready.
- No op value is illegal. All 8 codes are defined.

## Timing
- Reset values: count=0, in_ready=1, out_valid=0, out_data=0, res_count=0. Buffer contents are cleared to 0.
- Reset asserted mid-operation discards buffered results immediately (asynchronous). The first accept is allowed on the first rising edge after deassertion.
- Latency: accept at edge N gives out_valid=1 after edge N with the result, when count was 0.
- Throughput: 1 result/cycle with out_ready held high. With out_ready low, exactly 2 sets are accepted, then in_ready=0.
- in_ready depends only on registered count, with no combinational path from out_ready. out_valid and out_data are registered outputs.

## Configuration
- LOGIC_OP_UNIT_REDUCE_EN defined: adds outputs out_red_and, out_red_or and out_red_xor (each 1 bit). They are the reductions of the head result word, stored per buffer entry alongside data, and reset to 0.
- Not defined: these ports and their storage are absent. All other behaviour is identical.

## Structure
- Package logic_op_pkg holds:
  - the 3-bit op type with named constants OP_AND..OP_NOT
  - the WIDTH/NUM_IN legal-range constants
  - the function computing an op over the operand vector
- Sub-module logic_op_fifo2: the 2-entry buffer, parametrised on payload width (WIDTH, plus 3 when reduce is enabled), exposing count-based ready/valid.
- The top level is the op function, the FIFO instance and the saturating counter.

## Test plan
- Reset then idle: in_ready=1, out_valid=0, out_data=0, res_count=0. Assert rst mid-stream with 2 entries held: out_valid drops to 0 without waiting for a clock edge.
- WIDTH=8, NUM_IN=2, op AND, operand pairs (00,00),(00,FF),(FF,00),(FF,FF) with out_ready=1 → results 00,00,00,FF, one per cycle, latency 1, res_count=4.
- NUM_IN=3, operands A5,0F,F0:
  - ops 0..7 give 00, FF, 5A, FF, 00, A5, A5, 5A
  - op 7 (NOT) uses operand 0 only
- Backpressure: out_ready=0 and three back-to-back sets → in_ready=0 after the 2nd accept and the 3rd is held. Raise out_ready → outputs appear in order, then the 3rd is accepted.
- Simultaneous push/pop at count=1 over 10 cycles → count stays 1 and the output order matches input order.
- CNT_W=4, 20 pops → res_count saturates at 15. With LOGIC_OP_UNIT_REDUCE_EN and result 5A: red_and=0, red_or=1, red_xor=0.
